pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit, 8-register pipelined processor. It detects load-use hazards and stalls the front end for a configurable number of bubbles. It flushes the front end on taken branches, freezes the whole pipeline while data memory is busy, and latches the processor in a sticky HALT state. It drives the enable/flush inputs of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- `REG_W`, 3: register-specifier width.
- `LDUSE_BUBBLES`, 1: bubbles inserted per load-use hazard; legal values 1–3.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_rs`, `id_rt` in REG_W: ID source specifiers.
- `id_uses_rs`, `id_uses_rt` in 1: the source is actually read.
- `ex_valid` in 1: EX stage holds a real instruction.
- `ex_is_load` in 1: the EX instruction is a load.
- `ex_rd` in REG_W: EX destination specifier.
- `br_taken` in 1: a branch or jump resolved taken in EX this cycle.
- `mem_busy` in 1: data memory not ready.
- `halt_req` in 1: a HALT instruction reached WB.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en` out 1: register load enables.
- `ifid_flush`, `idex_flush` out 1: synchronous bubble insert, taking effect at the next posedge.
- `halted` out 1: processor halted.
- `state` out 2: current FSM state.
- `stall_cnt`, `flush_cnt` out CNT_W: performance counters.

## Operation
- FSM states: RUN=00, LDSTALL=01, MEMWAIT=10, HALT=11.
- Outputs are Mealy: decoded combinationally from the state and the current inputs. State, the bubble counter `bcnt` (2b), `saved_state` and the counters are registered.
- hazard = `ex_valid & ex_is_load & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- Priority of events within one cycle, highest first: `halt_req` > `mem_busy` > `br_taken` > hazard / LDSTALL.
- `halt_req` (any state except HALT):
  - Outputs: all enables 0, no flush.
  - Next state HALT. `halted`=1 from the next cycle.
- HALT:
  - All enables 0, flushes 0, `halted`=1.
  - Exits only on reset. All inputs are ignored.
- `mem_busy`=1 (RUN or LDSTALL):
  - Outputs: all enables 0, flushes 0.
  - `saved_state` <= state; next state MEMWAIT. `bcnt` is held.
- MEMWAIT:
  - While `mem_busy`=1: all enables 0.
  - The cycle `mem_busy`=0: outputs are evaluated as if in `saved_state` with the current inputs, and the FSM transitions accordingly. No extra dead cycle.
  - `br_taken` is ignored while `mem_busy`=1; upstream holds it until the pipeline advances.
- `br_taken` (RUN or LDSTALL):
  - Outputs: `pc_en`=1, `ifid_en`=1, `idex_en`=1, `exmem_en`=1, `ifid_flush`=1, `idex_flush`=1.
  - Next state RUN; `bcnt` cleared. This aborts any pending load-use bubbles.
- hazard in RUN:
  - Outputs: `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_flush`=1, `exmem_en`=1.
  - If `LDUSE_BUBBLES`>1: `bcnt` <= `LDUSE_BUBBLES`-1, next state LDSTALL.
- LDSTALL:
  - Outputs identical to a RUN hazard cycle.
  - `bcnt` decrements each cycle; go to RUN after the cycle in which `bcnt`==1.
- RUN, no event: all enables 1, flushes 0.
- `stall_cnt` increments on any cycle with `pc_en`=0 and state≠HALT. `halt_req` cycles do not count.
- `flush_cnt` increments on each `br_taken` flush.
- Both counters saturate at all-ones.

## Timing
- Hazard, flush and freeze responses are combinational: they take effect at the same posedge that would otherwise advance the pipeline.
- Load-use penalty is exactly `LDUSE_BUBBLES` cycles; branch penalty is 2 bubbles.
- Reset while `rst`=0:
  - state=RUN, `bcnt`=0, `saved_state`=RUN, counters=0.
  - Outputs forced: enables 0, `ifid_flush`=`idex_flush`=1, `halted`=0.
  - The first posedge after release behaves as RUN.
- Reset asserted mid-LDSTALL or mid-MEMWAIT clears all state immediately (asynchronous).

## Configuration
- `PIPE_HAZARD_CTRL_PERF_EN` defined: `stall_cnt`/`flush_cnt` registers and their increment logic are compiled in.
- Not defined: no counter flops; `stall_cnt`/`flush_cnt` are tied to 0. All other behaviour is identical.

## Test plan
- Reset held 3 cycles, then released with all inputs 0 → during reset enables 0 and flushes 1; after release state=00, all enables 1, counters 0.
- `LDUSE_BUBBLES`=2; `ex_is_load`=1, `ex_rd`=3, `id_rs`=3, `id_uses_rs`=1 → 2 cycles of `pc_en`=0 with `idex_flush`=1, state 00→01→00, `stall_cnt`=2. Repeat with `id_uses_rs`=0 → no stall.
- Hazard cycle, then `br_taken`=1 the next cycle (in LDSTALL) → both flushes 1, `pc_en`=1, state back to 00, `flush_cnt`=1.
- `mem_busy` held 4 cycles starting in LDSTALL with `bcnt`=1 → 4 cycles of all enables 0, state=10, then 1 remaining bubble, then RUN; `stall_cnt` incremented by 5.
- `halt_req`, `mem_busy` and `br_taken` asserted together → state 11, `halted`=1, and it stays halted across 10 cycles of arbitrary inputs. Asynchronous reset then returns state=00 without waiting for `clk`.
- With the macro undefined, repeat the hazard scenario → identical control outputs, counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 16-bit, 8-register pipelined core.
// It stalls the front end on load-use hazards, flushes it on taken branches,
// freezes the whole pipeline while data memory is busy and latches a sticky
// HALT. Control outputs are Mealy: they are decoded from the state and the
// inputs of the current cycle.
//
// Ports
//   clk, rst (async, active-low)
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt   ID stage operands
//   ex_valid, ex_is_load, ex_rd                      EX stage producer
//   br_taken, mem_busy, halt_req                     pipeline events
//   pc_en, ifid_en, idex_en, exmem_en                register load enables
//   ifid_flush, idex_flush                           bubble insert (next posedge)
//   halted, state                                    status
//   stall_cnt, flush_cnt                             performance counters
//
// Build option: define PIPE_HAZARD_CTRL_PERF_EN to compile in the counters.
// Without it, stall_cnt and flush_cnt are tied to 0.
//
// state   | meaning
// RUN     | normal flow, hazard check active
// LDSTALL | inserting the remaining load-use bubbles (bcnt left)
// MEMWAIT | frozen on mem_busy; resumes as saved_state with no dead cycle
// HALT    | sticky halt, left only through reset

module pipe_hazard_ctrl #(
  parameter int REG_W         = 3,
  parameter int LDUSE_BUBBLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10,
    HALT    = 2'b11
  } state_t;

  state_t     state_q, state_d;
  state_t     saved_q, saved_d;
  state_t     eff_state;
  logic [1:0] bcnt_q, bcnt_d;
  logic       hazard;

  assign hazard = ex_valid & ex_is_load & id_valid &
                  ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      bcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    bcnt_d     = bcnt_q;
    eff_state  = state_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (state_q == HALT || halt_req || mem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      if (state_q != HALT) begin
        if (halt_req) begin
          state_d = HALT;
        end else begin
          // Only capture on entry so a long freeze keeps the original state.
          if (state_q != MEMWAIT) saved_d = state_q;
          state_d = MEMWAIT;
        end
      end
    end else begin
      // Leaving MEMWAIT: behave this very cycle as the frozen state.
      eff_state = (state_q == MEMWAIT) ? saved_q : state_q;
      if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        bcnt_d     = 2'd0;
        state_d    = RUN;
      end else if (eff_state == LDSTALL || hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (eff_state == LDSTALL) begin
          bcnt_d  = bcnt_q - 2'd1;
          state_d = (bcnt_q == 2'd1) ? RUN : LDSTALL;
        end else if (LDUSE_BUBBLES > 1) begin
          bcnt_d  = 2'(LDUSE_BUBBLES - 1);
          state_d = LDSTALL;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end

    // Hold the pipeline empty while reset is asserted.
    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == HALT);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = ~pc_en & (state_q != HALT) & ~halt_req;
  // Both flushes with a running PC only happens on a taken-branch flush.
  assign flush_inc = ifid_flush & pc_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with LDUSE_BUBBLES=2.
// ctrl vector = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}.

module tb_pipe_hazard_ctrl;

  localparam logic [5:0] C_RUN   = 6'b111100;
  localparam logic [5:0] C_STALL = 6'b001101;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b000011;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs, id_uses_rt;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        ex_valid, ex_is_load, br_taken, mem_busy, halt_req;
  logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic [5:0]  ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};

  pipe_hazard_ctrl #(.REG_W(3), .LDUSE_BUBBLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .br_taken(br_taken), .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ec(input int v);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    return 32'(v);
`else
    if (v < 0) return 32'd0;
    return 32'd0;
`endif
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    br_taken = 0; mem_busy = 0; halt_req = 0;
  endtask

  task automatic set_hazard(input logic uses_rs);
    idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = 3;
    id_valid = 1; id_rs = 3; id_uses_rs = uses_rs;
  endtask

  // Advance one clock; inputs may then be changed, outputs checked at +1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_state", 32'(state), 0);
    chk("rst_halted", 32'(halted), 0);
    rst = 1;
    #1;
    chk("run_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("run_state", 32'(state), 0);
    chk("run_stall0", 32'(stall_cnt), 0);
    chk("run_flush0", 32'(flush_cnt), 0);
    tick();

    // Load-use hazard: two bubbles.
    set_hazard(1'b1); #1;
    chk("hz1_ctrl", 32'(ctrl), 32'(C_STALL));
    chk("hz1_state", 32'(state), 0);
    tick();
    idle(); #1;
    chk("hz2_ctrl", 32'(ctrl), 32'(C_STALL));
    chk("hz2_state", 32'(state), 1);
    tick();
    chk("hz_end_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("hz_end_state", 32'(state), 0);
    chk("hz_stall_cnt", 32'(stall_cnt), ec(2));

    // Same specifiers but source not read: no stall.
    set_hazard(1'b0); #1;
    chk("nohz_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("nohz_stall_cnt", 32'(stall_cnt), ec(2));

    // Branch in LDSTALL aborts the remaining bubble.
    set_hazard(1'b1); #1;
    chk("bh_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    idle(); br_taken = 1; #1;
    chk("br_state_pre", 32'(state), 1);
    chk("br_ctrl", 32'(ctrl), 32'(C_FLUSH));
    tick();
    idle(); #1;
    chk("br_state", 32'(state), 0);
    chk("br_ctrl_after", 32'(ctrl), 32'(C_RUN));
    chk("br_flush_cnt", 32'(flush_cnt), ec(1));
    chk("br_stall_cnt", 32'(stall_cnt), ec(3));

    // Freeze for 4 cycles in LDSTALL with one bubble left.
    set_hazard(1'b1); #1;
    tick();
    idle(); mem_busy = 1; #1;
    chk("mw0_state", 32'(state), 1);
    chk("mw0_ctrl", 32'(ctrl), 32'(C_FRZ));
    for (int i = 0; i < 3; i++) begin
      tick();
      br_taken = (i == 1);
      #1;
      chk("mw_state", 32'(state), 2);
      chk("mw_ctrl", 32'(ctrl), 32'(C_FRZ));
    end
    tick();
    idle(); #1;
    chk("mw_exit_state", 32'(state), 2);
    chk("mw_exit_ctrl", 32'(ctrl), 32'(C_STALL));
    tick();
    chk("mw_run_state", 32'(state), 0);
    chk("mw_run_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("mw_stall_cnt", 32'(stall_cnt), ec(9));
    chk("mw_flush_cnt", 32'(flush_cnt), ec(1));

    // Halt wins over everything and is sticky.
    idle(); halt_req = 1; mem_busy = 1; br_taken = 1; #1;
    chk("hr_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("hr_halted", 32'(halted), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      {id_valid, id_uses_rs, id_uses_rt, ex_valid, ex_is_load,
       br_taken, mem_busy, halt_req} = 8'($urandom);
      id_rs = 3'($urandom); id_rt = id_rs; ex_rd = id_rs;
      #1;
      chk("ht_state", 32'(state), 3);
      chk("ht_halted", 32'(halted), 1);
      chk("ht_ctrl", 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    chk("ht_stall_cnt", 32'(stall_cnt), ec(9));
    chk("ht_flush_cnt", 32'(flush_cnt), ec(1));
    idle();
    rst = 0; #1;
    chk("ar_state", 32'(state), 0);
    chk("ar_halted", 32'(halted), 0);
    chk("ar_ctrl", 32'(ctrl), 32'(C_RST));
    chk("ar_stall_cnt", 32'(stall_cnt), 0);

    // Reset mid-LDSTALL clears immediately.
    tick();
    rst = 1;
    set_hazard(1'b1); #1;
    tick();
    idle(); #1;
    chk("ls_state", 32'(state), 1);
    rst = 0; #1;
    chk("ls_rst_state", 32'(state), 0);
    tick();
    rst = 1; #1;
    chk("ls_after_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();
    chk("ls_after_state", 32'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
